ycfsm_sync: RTL and testbench

YCFSM_SYNC -- requirements
Module: ycfsm_sync

---
 rtl/morphle_pkg.sv | 20 ++
 rtl/ycfsm_sync_cell.sv | 64 ++++++
 rtl/ycfsm_sync.sv | 59 +++++
 tb/tb_ycfsm_sync.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/morphle_pkg.sv
// Shared dual-rail code constants and per-channel state enumeration
// for the ycfsm match-channel blocks.
package morphle_pkg;

  localparam logic [1:0] DR_NULL    = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } ch_state_e;

  function automatic logic dr_valid(input logic [1:0] code);
    return (code == DR_ZERO) || (code == DR_ONE);
  endfunction

endpackage

// File: rtl/ycfsm_sync_cell.sv
// Single dual-rail match channel: latches in==match on the first valid pair,
// holds it until in returns to NULL, and traps illegal codes until reset.
module ycfsm_sync_cell
  import morphle_pkg::*;
#(
  parameter int STRICT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  input  logic [1:0] match,
  output logic [1:0] out,
  output logic       err
);

  ch_state_e  state_p0, state_nxt;
  logic       load;
  logic [1:0] res_p0;
  logic [1:0] lat_p0;

  always_comb begin
    state_nxt = state_p0;
    load      = 1'b0;
    unique case (state_p0)
      ST_IDLE: begin
        if (match == DR_ILLEGAL || in == DR_ILLEGAL) begin
          state_nxt = ST_ERR;
        end else if (dr_valid(in) && dr_valid(match)) begin
          state_nxt = ST_HOLD;
          load      = 1'b1;
        end
      end
      ST_HOLD: begin
        if (match == DR_ILLEGAL || in == DR_ILLEGAL) begin
          state_nxt = ST_ERR;
        end else if (in == DR_NULL) begin
          state_nxt = ST_IDLE;
        end else if (in != lat_p0 && STRICT != 0) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: channel state (reset) and latched result/input (load-enabled only)
  always_ff @(posedge clk) begin
    if (reset) state_p0 <= ST_IDLE;
    else       state_p0 <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      res_p0 <= (in == match) ? DR_ONE : DR_ZERO;
      lat_p0 <= in;
    end
  end

  // The result register is only meaningful in HOLD; every other state shows NULL.
  assign out = (state_p0 == ST_HOLD) ? res_p0 : DR_NULL;
  assign err = (state_p0 == ST_ERR);

endmodule

// File: rtl/ycfsm_sync.sv
// Array of independent dual-rail match channels with an all-channels-ONE
// indicator and a saturating count of its rising edges.
module ycfsm_sync
  import morphle_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int STRICT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*CHANNELS-1:0] in,
  input  logic [2*CHANNELS-1:0] match,
  output logic [2*CHANNELS-1:0] out,
  output logic [CHANNELS-1:0]   err,
  output logic                  all_match,
  output logic [CNT_W-1:0]      done_count
);

  logic am_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    ycfsm_sync_cell #(
      .STRICT(STRICT)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .in   (in[2*k +: 2]),
      .match(match[2*k +: 2]),
      .out  (out[2*k +: 2]),
      .err  (err[k])
    );
  end

  // Cell outputs are pure functions of their state registers, so this stays
  // free of any input-to-output path; an ERR channel shows NULL and blocks it.
  always_comb begin
    all_match = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (out[2*k +: 2] != DR_ONE) all_match = 1'b0;
    end
  end

  // Stage p1: previous all_match for edge detection, saturating counter
  always_ff @(posedge clk) begin
    if (reset) begin
      am_p1      <= 1'b0;
      done_count <= '0;
    end else begin
      am_p1 <= all_match;
      if (all_match && !am_p1) done_count <= sat_inc(done_count);
    end
  end

endmodule

// File: tb/tb_ycfsm_sync.sv
// Bench for ycfsm_sync: three 2-channel instances (STRICT=1, STRICT=0, CNT_W=2)
// driven by common stimulus, with directed scenarios and a randomized model check.
module tb_ycfsm_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in, match;

  logic [3:0] o0, o1, o2;
  logic [1:0] e0, e1, e2;
  logic       a0, a1, a2;
  logic [7:0] d0, d1;
  logic [1:0] d2c;

  int n_tests = 0;
  int n_fail  = 0;

  ycfsm_sync #(.CHANNELS(2), .CNT_W(8), .STRICT(1)) dut (
    .clk(clk), .reset(reset), .in(in), .match(match),
    .out(o0), .err(e0), .all_match(a0), .done_count(d0));

  ycfsm_sync #(.CHANNELS(2), .CNT_W(8), .STRICT(0)) dut_s0 (
    .clk(clk), .reset(reset), .in(in), .match(match),
    .out(o1), .err(e1), .all_match(a1), .done_count(d1));

  ycfsm_sync #(.CHANNELS(2), .CNT_W(2), .STRICT(1)) dut_c2 (
    .clk(clk), .reset(reset), .in(in), .match(match),
    .out(o2), .err(e2), .all_match(a2), .done_count(d2c));

  always #5 clk = ~clk;

  // Reference model: expected output code, error flag and latched input per channel.
  logic [1:0] mo   [3][2];
  bit         me   [3][2];
  logic [1:0] ml   [3][2];
  int         mcnt [3];
  bit         mprev[3];
  int         strict_m[3] = '{1, 0, 1};
  int         cmax[3]     = '{255, 255, 3};

  logic [3:0] oa[3];
  logic [1:0] ea[3];
  logic       aa[3];
  logic [7:0] da[3];
  assign oa[0] = o0;  assign oa[1] = o1;  assign oa[2] = o2;
  assign ea[0] = e0;  assign ea[1] = e1;  assign ea[2] = e2;
  assign aa[0] = a0;  assign aa[1] = a1;  assign aa[2] = a2;
  assign da[0] = d0;  assign da[1] = d1;  assign da[2] = {6'b0, d2c};

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          mo[d][k] = 2'b00;
          me[d][k] = 1'b0;
        end
        mcnt[d]  = 0;
        mprev[d] = 1'b0;
      end else begin
        bit amnow;
        amnow = (mo[d][0] == 2'b10) && (mo[d][1] == 2'b10);
        if (amnow && !mprev[d] && mcnt[d] < cmax[d]) mcnt[d]++;
        mprev[d] = amnow;
        for (int k = 0; k < 2; k++) begin
          logic [1:0] i, m;
          i = in[2*k +: 2];
          m = match[2*k +: 2];
          if (me[d][k]) begin
          end else if (i == 2'b11 || m == 2'b11) begin
            me[d][k] = 1'b1;
            mo[d][k] = 2'b00;
          end else if (mo[d][k] == 2'b00) begin
            if (i != 2'b00 && m != 2'b00) begin
              mo[d][k] = (i == m) ? 2'b10 : 2'b01;
              ml[d][k] = i;
            end
          end else if (i == 2'b00) begin
            mo[d][k] = 2'b00;
          end else if (i != ml[d][k] && strict_m[d] != 0) begin
            me[d][k] = 1'b1;
            mo[d][k] = 2'b00;
          end
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in = 4'b1111; match = 4'b1010;
    step(); step();
    n_tests++; if (o0 !== 4'b0000) begin n_fail++; $display("FAIL reset_out: got %b expected 0000", o0); end
    n_tests++; if (e0 !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", e0); end
    n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL reset_all_match: got %b expected 0", a0); end
    n_tests++; if (d0 !== 8'd0) begin n_fail++; $display("FAIL reset_done_count: got %0d expected 0", d0); end
    reset = 1'b0; in = 4'b0000; match = 4'b0000;
    step();
  endtask

  task automatic test_compare();
    in = 4'b1001; match = 4'b1010;
    step();
    n_tests++; if (o0 !== 4'b1001) begin n_fail++; $display("FAIL compare_out: got %b expected 1001", o0); end
    n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL compare_all_match: got %b expected 0", a0); end
    in = 4'b0000;
    step();
    n_tests++; if (o0 !== 4'b0000) begin n_fail++; $display("FAIL compare_rtz: got %b expected 0000", o0); end
  endtask

  task automatic test_count();
    for (int r = 0; r < 5; r++) begin
      in = 4'b1010; match = 4'b1010;
      step();
      n_tests++; if (o0 !== 4'b1010) begin n_fail++; $display("FAIL count_out[%0d]: got %b expected 1010", r, o0); end
      n_tests++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL count_all_match[%0d]: got %b expected 1", r, a0); end
      step();
      in = 4'b0000;
      step();
      n_tests++; if (o0 !== 4'b0000) begin n_fail++; $display("FAIL count_rtz[%0d]: got %b expected 0000", r, o0); end
      if (r == 0) begin
        n_tests++; if (d0 !== 8'd1) begin n_fail++; $display("FAIL count_first: got %0d expected 1", d0); end
      end
    end
    step();
    n_tests++; if (d0 !== 8'd5) begin n_fail++; $display("FAIL count_total: got %0d expected 5", d0); end
    n_tests++; if (d2c !== 2'd3) begin n_fail++; $display("FAIL count_saturate: got %0d expected 3", d2c); end
  endtask

  task automatic test_reset_midhold();
    in = 4'b1010; match = 4'b1010;
    step(); step();
    n_tests++; if (a2 !== 1'b1) begin n_fail++; $display("FAIL midhold_all_match: got %b expected 1", a2); end
    reset = 1'b1;
    step();
    n_tests++; if (o2 !== 4'b0000) begin n_fail++; $display("FAIL midhold_out: got %b expected 0000", o2); end
    n_tests++; if (d2c !== 2'd0) begin n_fail++; $display("FAIL midhold_count: got %0d expected 0", d2c); end
    n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL midhold_am: got %b expected 0", a0); end
    reset = 1'b0; in = 4'b0000; match = 4'b0000;
    step();
  endtask

  task automatic test_wait();
    in = 4'b0001; match = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++; if (o0[1:0] !== 2'b00) begin n_fail++; $display("FAIL wait_out[%0d]: got %b expected 00", c, o0[1:0]); end
    end
    match = 4'b0001;
    step();
    n_tests++; if (o0[1:0] !== 2'b10) begin n_fail++; $display("FAIL wait_result: got %b expected 10", o0[1:0]); end
    in = 4'b0000;
    step();
  endtask

  task automatic test_strict();
    in = 4'b0001; match = 4'b0001;
    step();
    n_tests++; if (o0[1:0] !== 2'b10) begin n_fail++; $display("FAIL strict_hold: got %b expected 10", o0[1:0]); end
    in = 4'b0010;
    step();
    n_tests++; if (e0 !== 2'b01) begin n_fail++; $display("FAIL strict1_err: got %b expected 01", e0); end
    n_tests++; if (o0[1:0] !== 2'b00) begin n_fail++; $display("FAIL strict1_out: got %b expected 00", o0[1:0]); end
    n_tests++; if (e1 !== 2'b00) begin n_fail++; $display("FAIL strict0_err: got %b expected 00", e1); end
    n_tests++; if (o1[1:0] !== 2'b10) begin n_fail++; $display("FAIL strict0_out: got %b expected 10", o1[1:0]); end
    reset = 1'b1;
    step();
    reset = 1'b0; in = 4'b0000; match = 4'b0000;
    step();
  endtask

  task automatic test_err();
    in = 4'b0011; match = 4'b0000;
    step();
    n_tests++; if (e0 !== 2'b01) begin n_fail++; $display("FAIL err_set: got %b expected 01", e0); end
    n_tests++; if (o0 !== 4'b0000) begin n_fail++; $display("FAIL err_out: got %b expected 0000", o0); end
    in = 4'b0000;
    step();
    n_tests++; if (e0 !== 2'b01) begin n_fail++; $display("FAIL err_sticky_null: got %b expected 01", e0); end
    in = 4'b1001; match = 4'b1101;
    step();
    n_tests++; if (e0 !== 2'b11) begin n_fail++; $display("FAIL err_match_priority: got %b expected 11", e0); end
    n_tests++; if (o0 !== 4'b0000) begin n_fail++; $display("FAIL err_sticky_out: got %b expected 0000", o0); end
    reset = 1'b1;
    step();
    n_tests++; if (e0 !== 2'b00) begin n_fail++; $display("FAIL err_reset: got %b expected 00", e0); end
    reset = 1'b0; in = 4'b0000; match = 4'b0000;
    step();
  endtask

  function automatic logic [1:0] rcode();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 2'b11;
    return 2'(r % 3);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      in    = {rcode(), rcode()};
      match = ($urandom_range(0, 3) == 0) ? {rcode(), rcode()} : in;
      step();
      for (int d = 0; d < 3; d++) begin
        logic [3:0] xo;
        logic [1:0] xe;
        logic       xa;
        xo = {mo[d][1], mo[d][0]};
        xe = {me[d][1], me[d][0]};
        xa = (mo[d][0] == 2'b10) && (mo[d][1] == 2'b10);
        n_tests++;
        if (oa[d] !== xo || ea[d] !== xe || aa[d] !== xa || da[d] !== 8'(mcnt[d])) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d: got out=%b err=%b am=%b cnt=%0d expected out=%b err=%b am=%b cnt=%0d",
                   c, d, oa[d], ea[d], aa[d], da[d], xo, xe, xa, mcnt[d]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; in = 4'b0000; match = 4'b0000;
    test_reset();
    test_compare();
    test_count();
    test_reset_midhold();
    test_wait();
    test_strict();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
